// File: rtl/sweep_equiv_checker.sv
// Exhaustive equivalence sweeper: drives all 2^N_IN vectors to two implementations and compares results.
// Optional macro SWEEP_EQUIV_TRUTH_CAPTURE_EN adds a truth_table output capturing res_a[0] per vector.
module sweep_equiv_checker #(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 1,
    parameter int SETTLE_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [N_OUT-1:0]    res_a,
    input  logic [N_OUT-1:0]    res_b,
    output logic [N_IN-1:0]     vec,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_IN:0]       mismatch_count,
    output logic                first_fail_valid,
`ifdef SWEEP_EQUIV_TRUTH_CAPTURE_EN
    output logic [2**N_IN-1:0]  truth_table,
`endif
    output logic [N_IN-1:0]     first_fail_vec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE = 8'(SETTLE_CYC);

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [7:0]      sub_q, sub_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffvec_q, ffvec_d;
`ifdef SWEEP_EQUIV_TRUTH_CAPTURE_EN
    logic [2**N_IN-1:0] truth_q, truth_d;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        vec_d   = vec_q;
        sub_d   = sub_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
`ifdef SWEEP_EQUIV_TRUTH_CAPTURE_EN
        truth_d = truth_q;
`endif
        if (abort) begin
            // Results and first-fail info are kept for post-mortem debug.
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            vec_d   = '0;
            sub_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = SWEEP;
                        vec_d   = '0;
                        sub_d   = '0;
                        cnt_d   = '0;
                        ffv_d   = 1'b0;
                        ffvec_d = '0;
                        pass_d  = 1'b0;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
`ifdef SWEEP_EQUIV_TRUTH_CAPTURE_EN
                        truth_d = '0;
`endif
                    end
                end
                SWEEP: begin
                    if (sub_q != SETTLE) begin
                        sub_d = sub_q + 8'd1;
                    end else begin
                        if (res_a != res_b) begin
                            cnt_d = cnt_q + (N_IN+1)'(1);
                            if (!ffv_q) begin
                                ffv_d   = 1'b1;
                                ffvec_d = vec_q;
                            end
                        end
`ifdef SWEEP_EQUIV_TRUTH_CAPTURE_EN
                        truth_d[vec_q] = res_a[0];
`endif
                        sub_d = '0;
                        if (vec_q == '1) begin
                            // Final compare is folded into pass via the updated count.
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (cnt_d == '0);
                        end else begin
                            vec_d = vec_q + N_IN'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            sub_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cnt_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
`ifdef SWEEP_EQUIV_TRUTH_CAPTURE_EN
            truth_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            state_q <= state_d;
            vec_q   <= vec_d;
            sub_q   <= sub_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
`ifdef SWEEP_EQUIV_TRUTH_CAPTURE_EN
            truth_q <= truth_d;
`endif
        end
    end

    assign vec              = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign mismatch_count   = cnt_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;
`ifdef SWEEP_EQUIV_TRUTH_CAPTURE_EN
    assign truth_table      = truth_q;
`endif

endmodule

// File: tb/tb_sweep_equiv_checker.sv
// Self-checking bench for sweep_equiv_checker (N_IN=4, SETTLE_CYC=1): table-driven sweeps plus abort/reset sequences.
module tb_sweep_equiv_checker;

    localparam int N_IN = 4;
    localparam int N_OUT = 1;
    localparam int SETTLE_CYC = 1;
    localparam int SWEEP_CYC = (2**N_IN) * (SETTLE_CYC + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [N_OUT-1:0]  res_a, res_b;
    logic [N_IN-1:0]   vec;
    logic              busy, done, pass, first_fail_valid;
    logic [N_IN:0]     mismatch_count;
    logic [N_IN-1:0]   first_fail_vec;
`ifdef SWEEP_EQUIV_TRUTH_CAPTURE_EN
    logic [2**N_IN-1:0] truth_table;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int mode = 0;   // 0: equal, 1: differ at vec 5 and 12, 2: always differ

    always #5 clk = ~clk;

    // Both implementations compute vec[0]^vec[1]; B is corrupted according to mode.
    always_comb begin
        res_a = vec[0] ^ vec[1];
        res_b = res_a;
        if (mode == 2 || (mode == 1 && (vec == 4'd5 || vec == 4'd12)))
            res_b = ~res_a;
    end

    sweep_equiv_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .res_a(res_a),
        .res_b(res_b),
        .vec(vec),
        .busy(busy),
        .done(done),
        .pass(pass),
        .mismatch_count(mismatch_count),
        .first_fail_valid(first_fail_valid),
`ifdef SWEEP_EQUIV_TRUTH_CAPTURE_EN
        .truth_table(truth_table),
`endif
        .first_fail_vec(first_fail_vec)
    );

    typedef struct {
        int           mode;
        bit           poke_start;
        logic [N_IN:0] exp_cnt;
        logic         exp_ffv;
        logic [N_IN-1:0] exp_ffvec;
        logic         exp_pass;
    } sweep_rec_t;

    sweep_rec_t table_q[3];
    sweep_rec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input sweep_rec_t rec);
        sweep_rec_t got;
        int cyc;
        mode = rec.mode;
        start = 1'b1;
        sb.push_back(rec);
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < SWEEP_CYC + 8) begin
            if (cyc < SWEEP_CYC) begin
                check("sweep_vec", 32'(vec), 32'(cyc / (SETTLE_CYC + 1)));
                check("sweep_busy", 32'(busy), 32'd1);
            end
            // A start pulse mid-sweep must be ignored.
            start = (rec.poke_start && vec == 4'd3);
            tick();
            start = 1'b0;
            cyc++;
        end
        check("done_latency", 32'(cyc), 32'(SWEEP_CYC));
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            got = sb.pop_front();
            check("done", 32'(done), 32'd1);
            check("busy_end", 32'(busy), 32'd0);
            check("vec_end", 32'(vec), 32'hF);
            check("mismatch_count", 32'(mismatch_count), 32'(got.exp_cnt));
            check("first_fail_valid", 32'(first_fail_valid), 32'(got.exp_ffv));
            check("first_fail_vec", 32'(first_fail_vec), 32'(got.exp_ffvec));
            check("pass", 32'(pass), 32'(got.exp_pass));
`ifdef SWEEP_EQUIV_TRUTH_CAPTURE_EN
            check("truth_table", 32'(truth_table), 32'h6666);
`endif
        end
    endtask

    initial begin
        table_q[0] = '{mode: 0, poke_start: 1'b1, exp_cnt: 5'd0,  exp_ffv: 1'b0, exp_ffvec: 4'd0, exp_pass: 1'b1};
        table_q[1] = '{mode: 1, poke_start: 1'b0, exp_cnt: 5'd2,  exp_ffv: 1'b1, exp_ffvec: 4'd5, exp_pass: 1'b0};
        table_q[2] = '{mode: 2, poke_start: 1'b0, exp_cnt: 5'd16, exp_ffv: 1'b1, exp_ffvec: 4'd0, exp_pass: 1'b0};

        #12;
        check("rst_vec", 32'(vec), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_cnt", 32'(mismatch_count), 32'd0);
        check("rst_ffv", 32'(first_fail_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Abort at vec 7 with start also high: abort wins, debug results retained.
        begin
            int guard = 0;
            mode = 1;
            start = 1'b1;
            tick();
            start = 1'b0;
            while (vec != 4'd7 && guard < 40) begin
                tick();
                guard++;
            end
            check("abort_reach_vec7", 32'(vec), 32'd7);
            start = 1'b1;
            abort = 1'b1;
            tick();
            start = 1'b0;
            abort = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_pass", 32'(pass), 32'd0);
            check("abort_vec", 32'(vec), 32'd0);
            check("abort_cnt_kept", 32'(mismatch_count), 32'd1);
            check("abort_ffv_kept", 32'(first_fail_valid), 32'd1);
            check("abort_ffvec_kept", 32'(first_fail_vec), 32'd5);
            tick();
            check("abort_stays_idle", 32'(busy), 32'd0);
        end

        for (int i = 0; i < 3; i++)
            run_sweep(table_q[i]);

        // DONE holds results without a new start.
        repeat (3) tick();
        check("hold_done", 32'(done), 32'd1);
        check("hold_vec", 32'(vec), 32'hF);
        check("hold_cnt", 32'(mismatch_count), 32'd16);

        // Asynchronous reset mid-sweep, asserted between clock edges.
        mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_vec", 32'(vec), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_cnt", 32'(mismatch_count), 32'd0);
        check("async_rst_ffv", 32'(first_fail_valid), 32'd0);
        check("async_rst_ffvec", 32'(first_fail_vec), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
`ifdef SWEEP_EQUIV_TRUTH_CAPTURE_EN
        check("async_rst_truth", 32'(truth_table), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
